// File: rtl/conv_acc_collect.sv
// Shift-and-add collector for the bit-serial PIM datapath: weights per-column ADC
// samples by bit-plane significance, accumulates per column, then drains results.
module conv_acc_collect #(
  parameter int INPUT_P = 4,
  parameter int DEPTH   = 32,
  parameter int ADC_P   = 4,
  parameter int AW      = $clog2(DEPTH),
  parameter int ACC_W   = ADC_P + INPUT_P
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             adc_valid,
  input  logic [ADC_P-1:0] adc_data,
  output logic             adc_ready,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_data,
  output logic [AW-1:0]    out_addr,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  localparam int PW = $clog2(INPUT_P) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state_q;
  logic [AW-1:0]    col_cnt_q;
  logic [PW-1:0]    plane_cnt_q;
  logic [AW-1:0]    drain_cnt_q;
  logic             done_q;
  logic [ACC_W-1:0] acc_q [DEPTH];

  logic             col_last;
  logic             plane_last;
  logic [ACC_W-1:0] sample_ext;

  assign col_last   = (col_cnt_q == AW'(DEPTH - 1));
  assign plane_last = (plane_cnt_q == PW'(INPUT_P - 1));
  assign sample_ext = ACC_W'(adc_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      col_cnt_q   <= '0;
      plane_cnt_q <= '0;
      drain_cnt_q <= '0;
      done_q      <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= ACCUM;
            col_cnt_q   <= '0;
            plane_cnt_q <= '0;
            drain_cnt_q <= '0;
          end
        end
        ACCUM: begin
          if (adc_valid) begin
            // Plane 0 overwrites, so stale results never need an explicit clear.
            if (plane_cnt_q == '0) begin
              acc_q[col_cnt_q] <= sample_ext;
            end else begin
              acc_q[col_cnt_q] <= acc_q[col_cnt_q] + (sample_ext << plane_cnt_q);
            end
            if (col_last) begin
              col_cnt_q <= '0;
              if (plane_last) begin
                state_q <= DRAIN;
              end else begin
                plane_cnt_q <= plane_cnt_q + PW'(1);
              end
            end else begin
              col_cnt_q <= col_cnt_q + AW'(1);
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            drain_cnt_q <= drain_cnt_q + AW'(1);
            if (drain_cnt_q == AW'(DEPTH - 1)) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign adc_ready = (state_q == ACCUM);
  assign out_valid = (state_q == DRAIN);
  assign busy      = (state_q == ACCUM) || (state_q == DRAIN);
  assign done      = done_q;
  assign out_data  = acc_q[drain_cnt_q];
  assign out_addr  = drain_cnt_q;

endmodule

// File: doc/conv_acc_collect.md
# conv_acc_collect

Shift-and-add collector on the output side of the bit-serial PIM convolution datapath. It receives the stream of per-column ADC results that the crossbar produces, one bit plane at a time, LSB plane first. It weights each sample by its bit-plane significance and accumulates a full-precision dot product per crossbar column. After the last plane it drains the DEPTH results downstream over a valid/ready handshake.

## Interface
- INPUT_P, 4: input activation precision; number of bit planes per operation.
- DEPTH, 32: crossbar columns per plane; must be a power of two, at least 2.
- ADC_P, 4: ADC sample width.
- AW (derived), clogb2(DEPTH): column address width.
- ACC_W (derived), ADC_P+INPUT_P: accumulator and result width.

Ports (clock and reset first):
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset; asynchronous and active-high. All state clears immediately.
- start  in  1  begin an operation; sampled only in IDLE.
- adc_valid  in  1  adc_data carries a sample.
- adc_data  in  ADC_P  unsigned ADC result for the current column.
- adc_ready  out  1  block accepts a sample; high exactly in ACCUM.
- out_valid  out  1  out_data/out_addr valid; high exactly in DRAIN.
- out_data  out  ACC_W  accumulated result for column out_addr.
- out_addr  out  AW  column index of out_data.
- out_ready  in  1  downstream accepts the result.
- busy  out  1  high in ACCUM and DRAIN.
- done  out  1  one-cycle pulse after the final drain handshake.

## Operation
- Storage is DEPTH accumulators of ACC_W bits, plus the counters col_cnt (AW bits), plane_cnt (clogb2(INPUT_P)+1 bits) and drain_cnt (AW bits).
- State machine states are IDLE, ACCUM and DRAIN.
- **IDLE.** If start=1, go to ACCUM and clear col_cnt, plane_cnt and drain_cnt.
  - adc_valid is ignored in IDLE.
  - Accumulators hold their last values.
- **ACCUM.** An accept is adc_valid and adc_ready both high.
  - When plane_cnt=0: acc[col_cnt] <= adc_data, zero-extended. This overwrite means no separate clear cycle is needed.
  - Otherwise: acc[col_cnt] <= acc[col_cnt] + (adc_data << plane_cnt).
  - col_cnt increments on each accept and wraps from DEPTH-1 to 0; plane_cnt increments on that wrap.
  - On the accept at plane INPUT_P-1 and column DEPTH-1, go to DRAIN.
  - start is ignored in ACCUM.
- **DRAIN.** out_data=acc[drain_cnt] and out_addr=drain_cnt.
  - On out_valid and out_ready, drain_cnt increments.
  - On the handshake at drain_cnt=DEPTH-1, go to IDLE and register done=1 for one cycle.
  - adc_valid and start are ignored in DRAIN.
- **Arithmetic.** Unsigned throughout. The maximum result is (2^ADC_P-1)(2^INPUT_P-1), which is below 2^ACC_W, so overflow cannot occur and no saturation logic exists.

## Timing
- **Reset.** While rst=1, on assertion and with no clock edge required:
  - state=IDLE and all counters are 0;
  - all accumulators are 0;
  - adc_ready=0, out_valid=0, out_data=0, out_addr=0, busy=0, done=0.
- **Reset mid-operation.** rst asserted in ACCUM or DRAIN aborts the operation. No done is produced and results are lost.
- **Output decode.** adc_ready, out_valid and busy are decoded from the state register only, so they do not depend combinationally on any input. out_data is a mux of the accumulator array indexed by drain_cnt.
- **Start latency.** start high at edge N puts ACCUM in effect after edge N, so adc_ready=1 from that cycle.
- **Accept.** A sample accepted at edge N is visible in acc after edge N.
- **Throughput.** One sample per cycle in ACCUM, with no bubbles required. adc_valid gaps are allowed; counters hold during gaps.
- **ACCUM to DRAIN.** out_valid=1 in the cycle immediately after the final accept. In that cycle, out_data already includes the final sample of column 0.
- **Drain rate.** One result per cycle while out_ready=1.
- **Backpressure.** With out_ready=0, out_data and out_addr stay stable.
- **Minimum operation length.** With no stalls, an operation is 1 + INPUT_P·DEPTH + DEPTH cycles from start to done.
- **done cycle.** The state is already IDLE, so a start in the same cycle as done is accepted (back-to-back operation).

## Test plan
- **Reset values:** with rst=1 and no clock edges → every output 0; after release with no start, adc_valid=1 → adc_ready=0 and nothing changes.
- **Saturated input:** defaults, all 128 samples = 15 → 32 results of 225, out_addr 0..31 in order, then done pulses once.
- **Plane weighting:** plane0 data=1, planes 1–2 data=0, plane3 data=2 for every column → every result equals 17.
- **Stalls and backpressure:** random adc_valid gaps plus out_ready toggled 50% → results identical to the stall-free run, and out_data/out_addr stable while out_ready=0.
- **Ignored controls:** start pulsed in ACCUM and in DRAIN, adc_valid high in DRAIN → no state or result change; then start in the done cycle → a new ACCUM begins and plane 0 overwrites the old values.
- **Reset abort:** rst asserted after 40 accepts → immediate IDLE with outputs 0; a fresh operation afterwards gives correct results.
